// File: rtl/syscall_unit.sv
// MIPS syscall handler: print-with-pause, exit/halt and a saturating
// count of serviced syscalls for the board display.
module syscall_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int PAUSE_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  syscall,
    input  logic [DATA_WIDTH-1:0] v0_data,
    input  logic [DATA_WIDTH-1:0] a0_data,
    input  logic                  resume,
    output logic                  stall,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_valid,
    output logic [CNT_WIDTH-1:0]  sys_count
);

    localparam int PW =
        (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [DATA_WIDTH-1:0] SVC_PINT = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] SVC_PHEX = DATA_WIDTH'(34);
    localparam logic [DATA_WIDTH-1:0] SVC_EXIT = DATA_WIDTH'(10);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [PW-1:0]         pcnt, pcnt_d;
    logic [DATA_WIDTH-1:0] disp_d;
    logic                  valid_d;
    logic [CNT_WIDTH-1:0]  count_d;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  is_print;
    logic                  is_exit;

    assign is_print = (v0_data == SVC_PINT) ||
                      (v0_data == SVC_PHEX);
    assign is_exit  = (v0_data == SVC_EXIT);

    // Saturate rather than wrap so the display never rolls back to 0
    assign count_inc = (sys_count == '1) ?
                       sys_count : sys_count + CNT_WIDTH'(1);

    always_comb begin
        state_d = state;
        pcnt_d  = pcnt;
        disp_d  = disp_data;
        valid_d = disp_valid;
        count_d = sys_count;
        unique case (state)
            IDLE: begin
                if (syscall) begin
                    count_d = count_inc;
                    if (is_print) begin
                        disp_d  = a0_data;
                        valid_d = 1'b1;
                        pcnt_d  = PW'(PAUSE_CYCLES - 1);
                        state_d = SHOW;
                    end else if (is_exit) begin
                        state_d = HALT;
                    end
                end
            end
            SHOW: begin
                if (resume || pcnt == '0) begin
                    pcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt - PW'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            sys_count  <= '0;
        end else begin
            state      <= state_d;
            pcnt       <= pcnt_d;
            disp_data  <= disp_d;
            disp_valid <= valid_d;
            sys_count  <= count_d;
        end
    end

    assign stall  = (state != IDLE);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_syscall_unit.sv
// Randomized bench for syscall_unit with a cycle-level reference model,
// run on a default instance and a small (CNT_WIDTH=2, PAUSE_CYCLES=1) one.
module tb_syscall_unit;

    logic        clk;
    logic        rst;
    logic        syscall;
    logic [31:0] v0_data;
    logic [31:0] a0_data;
    logic        resume;

    logic        stall_a, halted_a, valid_a;
    logic [31:0] disp_a;
    logic [15:0] count_a;

    logic        stall_b, halted_b, valid_b;
    logic [31:0] disp_b;
    logic [1:0]  count_b;

    int n_checks = 0;
    int n_pass   = 0;

    syscall_unit #(
        .DATA_WIDTH  (32),
        .PAUSE_CYCLES(4),
        .CNT_WIDTH   (16)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .syscall   (syscall),
        .v0_data   (v0_data),
        .a0_data   (a0_data),
        .resume    (resume),
        .stall     (stall_a),
        .halted    (halted_a),
        .disp_data (disp_a),
        .disp_valid(valid_a),
        .sys_count (count_a)
    );

    syscall_unit #(
        .DATA_WIDTH  (32),
        .PAUSE_CYCLES(1),
        .CNT_WIDTH   (2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .syscall   (syscall),
        .v0_data   (v0_data),
        .a0_data   (a0_data),
        .resume    (resume),
        .stall     (stall_b),
        .halted    (halted_b),
        .disp_data (disp_b),
        .disp_valid(valid_b),
        .sys_count (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining stall cycles, halt flag, display, count
    int unsigned m_pause[2] = '{4, 1};
    int unsigned m_max[2]   = '{65535, 3};
    int unsigned m_left[2];
    bit          m_halt[2];
    logic [31:0] m_disp[2];
    bit          m_valid[2];
    int unsigned m_cnt[2];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t",
                      tag, got, exp, $time);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_left[i]  = 0;
                m_halt[i]  = 0;
                m_disp[i]  = '0;
                m_valid[i] = 0;
                m_cnt[i]   = 0;
            end else if (m_halt[i]) begin
                // exit is permanent until reset
            end else if (m_left[i] > 0) begin
                if (resume || m_left[i] == 1) m_left[i] = 0;
                else m_left[i] = m_left[i] - 1;
            end else if (syscall) begin
                if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                if (v0_data == 1 || v0_data == 34) begin
                    m_disp[i]  = a0_data;
                    m_valid[i] = 1;
                    m_left[i]  = m_pause[i];
                end else if (v0_data == 10) begin
                    m_halt[i] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("a_stall",  64'(stall_a),
              64'(m_halt[0] || m_left[0] > 0));
        check("a_halted", 64'(halted_a), 64'(m_halt[0]));
        check("a_disp",   64'(disp_a),   64'(m_disp[0]));
        check("a_valid",  64'(valid_a),  64'(m_valid[0]));
        check("a_count",  64'(count_a),  64'(m_cnt[0]));
        check("b_stall",  64'(stall_b),
              64'(m_halt[1] || m_left[1] > 0));
        check("b_halted", 64'(halted_b), 64'(m_halt[1]));
        check("b_disp",   64'(disp_b),   64'(m_disp[1]));
        check("b_valid",  64'(valid_b),  64'(m_valid[1]));
        check("b_count",  64'(count_b),  64'(m_cnt[1]));
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge
    task automatic cyc(input logic        r,
                       input logic        s,
                       input logic [31:0] v0,
                       input logic [31:0] a0,
                       input logic        res);
        rst     = r;
        syscall = s;
        v0_data = v0;
        a0_data = a0;
        resume  = res;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] v0;
        int unsigned sel;
        rst     = 1'b1;
        syscall = 1'b0;
        v0_data = '0;
        a0_data = '0;
        resume  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_halt[i] = 0; m_disp[i] = '0;
            m_valid[i] = 0; m_cnt[i] = 0;
        end

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // print hex, full pause; a0 changes afterwards
        cyc(0, 1, 34, 32'hDEADBEEF, 0);
        for (int k = 0; k < 5; k++)
            cyc(0, 0, 34, 32'h1234_0000 + k, 0);

        // early resume in 2nd SHOW cycle, syscall in SHOW ignored
        cyc(0, 1, 1, 5, 0);
        cyc(0, 1, 1, 99, 0);
        cyc(0, 1, 1, 77, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // no-op services
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 7, 32'hAAAA_0000 + k, 0);
            cyc(0, 0, 0, 0, 0);
        end

        // exit, then syscall/resume have no effect
        cyc(0, 1, 10, 3, 0);
        cyc(0, 1, 1, 8, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 34, 9, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // reset mid-SHOW
        cyc(0, 1, 1, 32'h55, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // reset together with syscall
        cyc(1, 1, 34, 32'h66, 0);
        cyc(0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: v0 = 32'd1;
                3, 4:    v0 = 32'd34;
                5:       v0 = 32'd10;
                6, 7:    v0 = 32'd7;
                default: v0 = $urandom;
            endcase
            cyc(($urandom_range(0, 99) < 3),
                ($urandom_range(0, 99) < 35),
                v0, $urandom,
                ($urandom_range(0, 99) < 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
